uart_rx_sampler: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 45 ++++
 rtl/uart_rx_sampler.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults, receiver state codes and the
// rounded baud divider helper for the UART datapath.
package uart_pkg;

    localparam int UART_CLK_HZ     = 50_000_000;
    localparam int UART_BAUD       = 115_200;
    localparam int UART_OVERSAMPLE = 16;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;
    localparam rx_state_t ST_BREAK  = 3'd5;

    // Clocks per sample tick, rounded to nearest.
    function automatic int calc_tick_div(
        input int clk_hz,
        input int baud,
        input int os
    );
        int den;
        den = baud * os;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running sample tick divider with a
// synchronous clear and an enable; shared by RX and future TX.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = calc_tick_div(
        UART_CLK_HZ, UART_BAUD, UART_OVERSAMPLE)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampled UART byte receiver, 3-sample vote.
// Define UART_RX_PARITY_EN for an even-parity bit (8E1 frames).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = UART_CLK_HZ,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int TICK_DIV   = calc_tick_div(
        CLK_HZ, BAUD, OVERSAMPLE)
) (
    input  logic       clk_50mhz,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int SW = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] V0_IDX =
        SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] V1_IDX =
        SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] V2_IDX =
        SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] LAST_IDX =
        SW'(OVERSAMPLE - 1);

    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    rx_state_t       state_q, state_d;
    logic [SW-1:0]   samp_q, samp_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      vote_q, vote_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_ok_q, par_ok_d;
`endif

    logic tick;
    logic tick_clr;
    logic mid_tick;
    logic bit_v;
    logic stop_ok;

    // Divider sits at zero while idle so the sample phase
    // is referenced to the detected falling edge.
    assign tick_clr = (state_q == ST_IDLE);

    uart_baud_tick #(
        .DIV   (TICK_DIV)
    ) u_tick (
        .clk   (clk_50mhz),
        .rst_n (rstn),
        .clr   (tick_clr),
        .en    (!tick_clr),
        .tick  (tick)
    );

    assign mid_tick = tick && (samp_q == V2_IDX);
    assign bit_v    = (vote_q[0] & vote_q[1])
                    | (vote_q[0] & rx_s_q)
                    | (vote_q[1] & rx_s_q);

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
    end

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        vote_d  = vote_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d = par_ok_q;
        stop_ok  = bit_v & par_ok_q;
`else
        stop_ok  = bit_v;
`endif

        if (tick) begin
            samp_d = samp_q + 1'b1;
            if (samp_q == V0_IDX) vote_d[0] = rx_s_q;
            if (samp_q == V1_IDX) vote_d[1] = rx_s_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                samp_d = '0;
                bit_d  = '0;
                if (!rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (mid_tick) begin
                    bit_d   = '0;
                    state_d = bit_v ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (mid_tick) begin
                    shift_d = {bit_v, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (mid_tick) begin
                    par_ok_d = ~(^shift_q ^ bit_v);
                    state_d  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start
                // edge is seen by IDLE.
                if (mid_tick) begin
                    if (stop_ok) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                    if (bit_v) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                        samp_d  = '0;
                    end
                end
            end
            ST_BREAK: begin
                // samp counts consecutive high ticks here.
                if (tick) begin
                    if (!rx_s_q) begin
                        samp_d = '0;
                    end else if (samp_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= ST_IDLE;
            samp_q    <= '0;
            bit_q     <= '0;
            vote_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            vote_q    <= vote_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_50mhz or negedge rstn) begin
        if (!rstn) begin
            par_ok_q <= 1'b0;
        end else begin
            par_ok_q <= par_ok_d;
        end
    end
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: randomized frame bench with a frame-level
// reference model (byte accepted iff stop high and parity good).
module tb_uart_rx_sampler;

    localparam int TICK = 27;
    localparam int OS   = 16;
    localparam int BIT  = TICK * OS;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk_50mhz = 1'b0;
    logic       rstn      = 1'b0;
    logic       rx        = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int n_checks   = 0;
    int n_errors   = 0;
    int n_valid    = 0;
    int n_ferr     = 0;
    int n_both     = 0;
    int n_unstable = 0;
    int n_busy     = 0;

    logic [7:0] got_q[$];
    logic [7:0] hold     = 8'h00;
    logic [7:0] exp_data = 8'h00;

    uart_rx_sampler dut (
        .clk_50mhz (clk_50mhz),
        .rstn      (rstn),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    always @(negedge clk_50mhz) begin
        if (!rstn) begin
            hold = data;
        end else begin
            if (valid) begin
                got_q.push_back(data);
                n_valid++;
            end
            if (frame_err) n_ferr++;
            if (valid && frame_err) n_both++;
            if (!valid && data !== hold) n_unstable++;
            if (busy) n_busy++;
            hold = data;
        end
    end

    task automatic drive_bit(input logic v, input int glo,
                             input int ghi);
        for (int c = 0; c < BIT; c++) begin
            rx = (c >= glo && c < ghi) ? ~v : v;
            @(negedge clk_50mhz);
        end
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (nbits * BIT) @(negedge clk_50mhz);
    endtask

    task automatic send_frame(input logic [7:0] b,
                              input logic stop,
                              input logic bad_par,
                              input int gbit,
                              input int glo,
                              input int ghi);
        logic [10:0] f;
`ifdef UART_RX_PARITY_EN
        f = {stop, (^b) ^ bad_par, b, 1'b0};
`else
        f = {bad_par, stop, b, 1'b0};
`endif
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (i == gbit) drive_bit(f[4'(i)], glo, ghi);
            else drive_bit(f[4'(i)], 0, 0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_50mhz);
        n_checks++;
        if (data !== 8'h00) begin
            n_errors++;
            $display("FAIL rst_data: got %0h want 00", data);
        end
        n_checks++;
        if (valid !== 1'b0 || frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_pulses: got %b%b want 00",
                     valid, frame_err);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        rstn = 1'b1;
        repeat (10) @(negedge clk_50mhz);
        n_checks++;
        if (busy !== 1'b0 || n_valid != 0 || n_ferr != 0) begin
            n_errors++;
            $display("FAIL post_rst_idle: busy %b v %0d fe %0d",
                     busy, n_valid, n_ferr);
        end
    endtask

    task automatic test_basic();
        int v0, f0, b0, db;
        v0 = n_valid;
        f0 = n_ferr;
        b0 = n_busy;
        send_frame(8'hA5, 1'b1, 1'b0, -1, 0, 0);
        idle(1);
        exp_data = 8'hA5;
        n_checks++;
        if (n_valid - v0 != 1) begin
            n_errors++;
            $display("FAIL a5_valid_cnt: got %0d want 1",
                     n_valid - v0);
        end else begin
            n_checks++;
            if (got_q[$] !== 8'hA5) begin
                n_errors++;
                $display("FAIL a5_data: got %0h want a5",
                         got_q[$]);
            end
        end
        n_checks++;
        if (n_ferr != f0) begin
            n_errors++;
            $display("FAIL a5_ferr: got %0d want 0", n_ferr - f0);
        end
        db = n_busy - b0;
        n_checks++;
        if (db < 9 * BIT + BIT / 4 || db > 9 * BIT + 3 * BIT / 4)
        begin
            n_errors++;
            $display("FAIL a5_busy_len: got %0d want ~%0d",
                     db, 9 * BIT + BIT / 2);
        end
    endtask

    task automatic test_false_start();
        int v0, f0, b0, db;
        v0 = n_valid;
        f0 = n_ferr;
        b0 = n_busy;
        rx = 1'b0;
        repeat (4 * TICK) @(negedge clk_50mhz);
        idle(2);
        db = n_busy - b0;
        n_checks++;
        if (db < 9 * TICK || db > 11 * TICK) begin
            n_errors++;
            $display("FAIL glitch_busy_len: got %0d want ~%0d",
                     db, 10 * TICK);
        end
        n_checks++;
        if (n_valid != v0 || n_ferr != f0) begin
            n_errors++;
            $display("FAIL glitch_pulses: v %0d fe %0d want 0 0",
                     n_valid - v0, n_ferr - f0);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_idle: busy %b want 0", busy);
        end
    endtask

    task automatic test_break();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0, -1, 0, 0);
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk_50mhz);
        n_checks++;
        if (n_ferr - f0 != 1 || n_valid != v0) begin
            n_errors++;
            $display("FAIL brk_pulses: fe %0d v %0d want 1 0",
                     n_ferr - f0, n_valid - v0);
        end
        n_checks++;
        if (data !== exp_data) begin
            n_errors++;
            $display("FAIL brk_data_hold: got %0h want %0h",
                     data, exp_data);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL brk_busy_low: got %b want 1", busy);
        end
        idle(2);
        n_checks++;
        if (busy !== 1'b0 || n_ferr - f0 != 1) begin
            n_errors++;
            $display("FAIL brk_exit: busy %b fe %0d want 0 1",
                     busy, n_ferr - f0);
        end
        send_frame(8'h11, 1'b1, 1'b0, -1, 0, 0);
        idle(1);
        exp_data = 8'h11;
        n_checks++;
        if (n_valid - v0 != 1) begin
            n_errors++;
            $display("FAIL brk_next_cnt: got %0d want 1",
                     n_valid - v0);
        end else begin
            n_checks++;
            if (got_q[$] !== 8'h11) begin
                n_errors++;
                $display("FAIL brk_next_data: got %0h want 11",
                         got_q[$]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = got_q.size();
        send_frame(8'h00, 1'b1, 1'b0, -1, 0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, -1, 0, 0);
        idle(1);
        exp_data = 8'hFF;
        n_checks++;
        if (got_q.size() - s0 != 2) begin
            n_errors++;
            $display("FAIL b2b_cnt: got %0d want 2",
                     got_q.size() - s0);
        end else begin
            n_checks++;
            if (got_q[s0] !== 8'h00 || got_q[s0+1] !== 8'hFF)
            begin
                n_errors++;
                $display("FAIL b2b_data: got %0h %0h want 00 ff",
                         got_q[s0], got_q[s0+1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int v0, f0;
        b = 8'h5A;
        drive_bit(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) drive_bit(b[3'(i)], 0, 0);
        rx = b[4];
        repeat (BIT / 2) @(negedge clk_50mhz);
        rstn = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || frame_err !== 1'b0 ||
            busy !== 1'b0 || data !== 8'h00) begin
            n_errors++;
            $display("FAIL midrst_async: v%b fe%b b%b d%0h",
                     valid, frame_err, busy, data);
        end
        repeat (3) @(negedge clk_50mhz);
        rx   = 1'b1;
        rstn = 1'b1;
        exp_data = 8'h00;
        v0 = n_valid;
        f0 = n_ferr;
        idle(1);
        send_frame(8'h77, 1'b1, 1'b0, -1, 0, 0);
        idle(1);
        exp_data = 8'h77;
        n_checks++;
        if (n_valid - v0 != 1 || n_ferr != f0) begin
            n_errors++;
            $display("FAIL midrst_cnt: v %0d fe %0d want 1 0",
                     n_valid - v0, n_ferr - f0);
        end else begin
            n_checks++;
            if (got_q[$] !== 8'h77) begin
                n_errors++;
                $display("FAIL midrst_data: got %0h want 77",
                         got_q[$]);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [7:0] b;
        logic       stop, bad_par, ok;
        int         mode, gbit, glo, ghi, v0, f0;
        for (int k = 0; k < n; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            bad_par = ($urandom_range(0, 3) == 0);
`else
            bad_par = 1'b0;
`endif
            mode = $urandom_range(0, 2);
            gbit = (mode == 0) ? -1 : $urandom_range(1, 8);
            // Mode 1 hits only early samples of a bit; mode 2
            // flips just the middle sample of the vote window.
            glo = (mode == 1) ? 2 * TICK : (OS / 2 + 1) * TICK - 3;
            ghi = (mode == 1) ? 4 * TICK : (OS / 2 + 1) * TICK + 7;
            ok  = stop && !bad_par;
            v0  = n_valid;
            f0  = n_ferr;
            send_frame(b, stop, bad_par, gbit, glo, ghi);
            if (ok) exp_data = b;
            n_checks++;
            if (n_valid - v0 != int'(ok) ||
                n_ferr - f0 != int'(!ok)) begin
                n_errors++;
                $display("FAIL rnd%0d_pulses: v %0d fe %0d ok %b",
                         k, n_valid - v0, n_ferr - f0, ok);
            end
            n_checks++;
            if (data !== exp_data) begin
                n_errors++;
                $display("FAIL rnd%0d_data: got %0h want %0h",
                         k, data, exp_data);
            end
            idle(stop ? $urandom_range(0, 1) : 2);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h03, 1'b1, 1'b0, -1, 0, 0);
        idle(1);
        exp_data = 8'h03;
        n_checks++;
        if (n_valid - v0 != 1 || data !== 8'h03) begin
            n_errors++;
            $display("FAIL par_good: v %0d d %0h want 1 03",
                     n_valid - v0, data);
        end
        v0 = n_valid;
        send_frame(8'h03, 1'b1, 1'b1, -1, 0, 0);
        idle(1);
        n_checks++;
        if (n_valid != v0 || n_ferr - f0 != 1) begin
            n_errors++;
            $display("FAIL par_bad: v %0d fe %0d want 0 1",
                     n_valid - v0, n_ferr - f0);
        end
    endtask
`endif

    task automatic test_integrity();
        n_checks++;
        if (n_both != 0) begin
            n_errors++;
            $display("FAIL both_pulses: got %0d want 0", n_both);
        end
        n_checks++;
        if (n_unstable != 0) begin
            n_errors++;
            $display("FAIL data_stable: got %0d want 0",
                     n_unstable);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_break();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random(5);
        test_integrity();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
